// File: rtl/fft_frame_loader.sv
// fft_frame_loader: collects a serial valid/ready stream of complex samples
// into N-point frames using two banks (ping-pong). One bank is presented to
// the FFT on zr/zi while the other fills.
module fft_frame_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_re,
  input  logic signed [DATA_WIDTH-1:0] s_im,
  input  logic                         s_last,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic signed [DATA_WIDTH-1:0] zr [0:N-1],
  output logic signed [DATA_WIDTH-1:0] zi [0:N-1],
  output logic                         frame_err,
  output logic [7:0]                   drop_cnt
);

  localparam int CW = $clog2(N);

  logic signed [DATA_WIDTH-1:0] r_bank_re [0:1][0:N-1];
  logic signed [DATA_WIDTH-1:0] r_bank_im [0:1][0:N-1];
  logic [1:0]                   r_bank_full;
  logic                         r_wr_sel;
  logic                         r_rd_sel;
  logic [CW-1:0]                r_wr_cnt;
  logic                         r_frame_err;
  logic [7:0]                   r_drop_cnt;

  logic w_accept;
  logic w_consume;
  logic w_at_end;

  // The write bank can only be full once the read side has not yet drained
  // it, so s_ready depends on registers alone.
  assign s_ready     = !r_bank_full[r_wr_sel];
  assign frame_valid = r_bank_full[r_rd_sel];
  assign frame_err   = r_frame_err;
  assign drop_cnt    = r_drop_cnt;

  assign w_accept  = s_valid && s_ready;
  assign w_consume = frame_valid && frame_ready;
  assign w_at_end  = (r_wr_cnt == CW'(N - 1));

  // Sample storage: clear on reset, otherwise write the accepted sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned k = 0; k < N; k++) begin
          r_bank_re[b][k] <= '0;
          r_bank_im[b][k] <= '0;
        end
      end
    end else if (w_accept) begin
      r_bank_re[r_wr_sel][r_wr_cnt] <= s_re;
      r_bank_im[r_wr_sel][r_wr_cnt] <= s_im;
    end
  end

  // Write/read bookkeeping; fill and drain touch different bank_full bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bank_full <= '0;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_wr_cnt    <= '0;
      r_frame_err <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_accept) begin
        if (w_at_end) begin
          r_bank_full[r_wr_sel] <= 1'b1;
          r_wr_sel              <= !r_wr_sel;
          r_wr_cnt              <= '0;
          if (!s_last) begin
            r_frame_err <= 1'b1;
          end
        end else if (s_last) begin
          r_wr_cnt    <= '0;
          r_frame_err <= 1'b1;
          if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
          end
        end else begin
          r_wr_cnt <= r_wr_cnt + CW'(1);
        end
      end
      if (w_consume) begin
        r_bank_full[r_rd_sel] <= 1'b0;
        r_rd_sel              <= !r_rd_sel;
      end
    end
  end

  // Present the read bank directly from storage.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      zr[k] = r_bank_re[r_rd_sel][k];
      zi[k] = r_bank_im[r_rd_sel][k];
    end
  end

endmodule
